xor_event_logger: RTL and testbench

Downstream consumer of the registered XOR pair outputs, `A_xor_out` and `B_xor_out`, from the decode/XOR stage. It counts rising edges on each XOR bit over a fixed window of enabled cycles. At the end of each window it queues one record, holding both counts, into a small first-word-fall-through FIFO. A host drains that FIFO through a valid/ready handshake.

---
 rtl/xor_event_logger.sv | 103 ++++++++++
 tb/tb_xor_event_logger.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/xor_event_logger.sv
// Counts rising edges of the A/B XOR bits over windows of WIN enabled cycles and queues {A_cnt, B_cnt} records in a FWFT FIFO.
// Build option: define XOR_EVENT_LOGGER_SAT_EN to make the edge counters saturate instead of wrapping.
module xor_event_logger #(
  parameter int CNT_W = 8,
  parameter int WIN   = 16,
  parameter int DEPTH = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     A_xor_in,
  input  logic                     B_xor_in,
  input  logic                     Enable_in,
  input  logic                     Rec_ready_in,
  output logic                     Rec_valid_out,
  output logic [2*CNT_W-1:0]       Rec_data_out,
  output logic [$clog2(DEPTH):0]   Level_out,
  output logic                     Overflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int WIN_W = $clog2(WIN);

  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt, input logic rise);
`ifdef XOR_EVENT_LOGGER_SAT_EN
    cnt_step = (rise && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;
`else
    cnt_step = rise ? cnt + 1'b1 : cnt;
`endif
  endfunction

  logic               a_q, b_q;
  logic [CNT_W-1:0]   a_cnt, b_cnt;
  logic [WIN_W-1:0]   win_cnt;
  logic [2*CNT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [LVL_W-1:0]   level;
  logic               overflow;

  logic               rise_a, rise_b, win_end, pop, push_ok;
  logic [CNT_W-1:0]   a_next, b_next;
  logic [2*CNT_W-1:0] rec;

  // Edge detect, count update and push/pop decisions for this cycle
  always_comb begin
    rise_a  = A_xor_in & ~a_q;
    rise_b  = B_xor_in & ~b_q;
    a_next  = cnt_step(a_cnt, rise_a);
    b_next  = cnt_step(b_cnt, rise_b);
    rec     = {a_next, b_next};
    win_end = Enable_in && (win_cnt == WIN_W'(WIN - 1));
    pop     = (level != '0) && Rec_ready_in;
    push_ok = win_end && ((level < LVL_W'(DEPTH)) || pop);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      a_cnt    <= '0;
      b_cnt    <= '0;
      win_cnt  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      a_q <= A_xor_in;
      b_q <= B_xor_in;
      if (Enable_in) begin
        if (win_end) begin
          a_cnt   <= '0;
          b_cnt   <= '0;
          win_cnt <= '0;
        end else begin
          a_cnt   <= a_next;
          b_cnt   <= b_next;
          win_cnt <= win_cnt + 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (win_end && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and level define which slots are live.
  // When full with a simultaneous pop, wr_ptr equals rd_ptr and the popped slot is reused.
  always_ff @(posedge Clock) begin
    if (push_ok) mem[wr_ptr] <= rec;
  end

  assign Rec_valid_out = (level != '0);
  assign Rec_data_out  = Rec_valid_out ? mem[rd_ptr] : '0;
  assign Level_out     = level;
  assign Overflow_out  = overflow;

endmodule

// File: tb/tb_xor_event_logger.sv
// Scoreboarded random + directed bench for xor_event_logger, checking an 8-bit and a 3-bit counter instance in parallel.
`timescale 1ns/1ps
module tb_xor_event_logger;

  localparam int WIN   = 16;
  localparam int DEPTH = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic A_xor_in = 1'b0, B_xor_in = 1'b0, Enable_in = 1'b0, Rec_ready_in = 1'b0;

  logic        v8, v3, o8, o3;
  logic [15:0] d8;
  logic [5:0]  d3;
  logic [2:0]  l8, l3;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  xor_event_logger #(.CNT_W(8), .WIN(WIN), .DEPTH(DEPTH)) u8 (
    .Clock(Clock), .Reset(Reset), .A_xor_in(A_xor_in), .B_xor_in(B_xor_in),
    .Enable_in(Enable_in), .Rec_ready_in(Rec_ready_in), .Rec_valid_out(v8),
    .Rec_data_out(d8), .Level_out(l8), .Overflow_out(o8));

  xor_event_logger #(.CNT_W(3), .WIN(WIN), .DEPTH(DEPTH)) u3 (
    .Clock(Clock), .Reset(Reset), .A_xor_in(A_xor_in), .B_xor_in(B_xor_in),
    .Enable_in(Enable_in), .Rec_ready_in(Rec_ready_in), .Rec_valid_out(v3),
    .Rec_data_out(d3), .Level_out(l3), .Overflow_out(o3));

  // Reference model: raw rise counts per window as integers, FIFO as queues.
  int qa[$], qb[$];
  int ref_a, ref_b, ref_en;
  int prev_a, prev_b;
  bit ref_ovf;

  function automatic int fld(int c, int w);
    int mx;
    mx = (1 << w) - 1;
`ifdef XOR_EVENT_LOGGER_SAT_EN
    return (c > mx) ? mx : c;
`else
    return c % (mx + 1);
`endif
  endfunction

  function automatic logic [15:0] exp8(int a, int b);
    return {8'(fld(a, 8)), 8'(fld(b, 8))};
  endfunction

  function automatic logic [5:0] exp3(int a, int b);
    return {3'(fld(a, 3)), 3'(fld(b, 3))};
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      qa.delete(); qb.delete();
      ref_a = 0; ref_b = 0; ref_en = 0;
      prev_a = 0; prev_b = 0; ref_ovf = 0;
    end else begin
      bit do_pop;
      if (Enable_in) begin
        ref_a += (A_xor_in && prev_a == 0) ? 1 : 0;
        ref_b += (B_xor_in && prev_b == 0) ? 1 : 0;
        ref_en++;
      end
      do_pop = (qa.size() > 0) && Rec_ready_in;
      if (do_pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (Enable_in && ref_en == WIN) begin
        if (qa.size() < DEPTH) begin
          qa.push_back(ref_a);
          qb.push_back(ref_b);
        end else begin
          ref_ovf = 1;
        end
        ref_a = 0; ref_b = 0; ref_en = 0;
      end
      prev_a = A_xor_in ? 1 : 0;
      prev_b = B_xor_in ? 1 : 0;
    end
  end

  // Monitor: compares whatever the DUTs present against the scoreboard head.
  always @(negedge Clock) begin
    bit ev;
    ev = (qa.size() != 0);
    chk("valid8", {31'd0, v8}, {31'd0, ev});
    chk("valid3", {31'd0, v3}, {31'd0, ev});
    chk("level8", {29'd0, l8}, qa.size());
    chk("level3", {29'd0, l3}, qa.size());
    chk("ovf8", {31'd0, o8}, {31'd0, ref_ovf});
    chk("ovf3", {31'd0, o3}, {31'd0, ref_ovf});
    if (ev) begin
      chk("data8", {16'd0, d8}, {16'd0, exp8(qa[0], qb[0])});
      chk("data3", {26'd0, d3}, {26'd0, exp3(qa[0], qb[0])});
    end
  end

  task automatic step(input logic rst, input logic a, input logic b, input logic en, input logic rdy);
    Reset = rst; A_xor_in = a; B_xor_in = b; Enable_in = en; Rec_ready_in = rdy;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rand_window(input logic rdy);
    for (int i = 0; i < WIN; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, rdy);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("rst_valid", {31'd0, v8}, 32'd0);
    chk("rst_data", {16'd0, d8}, 32'd0);
    chk("rst_level", {29'd0, l8}, 32'd0);
    chk("rst_ovf", {31'd0, o8}, 32'd0);

    // Basic record, also the narrow-counter case (8 rises into a 3-bit field)
    for (int i = 0; i < WIN; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b1, 1'b0);
    chk("basic_valid", {31'd0, v8}, 32'd1);
    chk("basic_data", {16'd0, d8}, 32'h0800);
`ifdef XOR_EVENT_LOGGER_SAT_EN
    chk("cntw_a3", {29'd0, d3[5:3]}, 32'd7);
`else
    chk("cntw_a3", {29'd0, d3[5:3]}, 32'd0);
`endif

    // Overflow: windows 2..5 with no consumer
    for (int w = 2; w <= 5; w++) begin
      rand_window(1'b0);
      if (w == 4) chk("ovf_level4", {29'd0, l8}, 32'd4);
    end
    chk("ovf_flag", {31'd0, o8}, 32'd1);
    chk("ovf_level", {29'd0, l8}, 32'd4);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_drained", {31'd0, v8}, 32'd0);

    // Full FIFO with a pop on the window-end cycle
    do_reset();
    for (int w = 0; w < 4; w++) rand_window(1'b0);
    for (int i = 0; i < WIN; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, (i == WIN - 1));
    chk("fullpop_level", {29'd0, l8}, 32'd4);
    chk("fullpop_ovf", {31'd0, o8}, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fullpop_drained", {31'd0, v8}, 32'd0);

    // Enable pause mid-window while A toggles
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b1, 1'b0);
    chk("pause_not_yet", {31'd0, v8}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pause_record", {31'd0, v8}, 32'd1);

    // Reset with two records and a partial window in flight
    rand_window(1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    do_reset();
    chk("midrst_valid", {31'd0, v8}, 32'd0);
    chk("midrst_level", {29'd0, l8}, 32'd0);
    chk("midrst_ovf", {31'd0, o8}, 32'd0);
    for (int i = 0; i < WIN - 1; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
    chk("midrst_not_yet", {31'd0, v8}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("midrst_record", {31'd0, v8}, 32'd1);

    // Random traffic with bursts of back-pressure and occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic rdy;
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
      step(($urandom_range(0, 499) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) != 0), rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
